// File: rtl/display_channel_sequencer.sv
// Rotating channel selector feeding a sequential double-dabble converter and a
// multiplexed seven-segment driver. Optional feature macro: DISP_CH_TAG_EN.
module display_channel_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int VAL_W     = 14,
    parameter int NUM_DIG   = 4,
    parameter int DWELL_CYC = 200000000,
    parameter int SCAN_CYC  = 100000,
    parameter int SAT_VAL   = 9999
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic [NUM_CH*VAL_W-1:0]                ch_values,
    input  logic [NUM_CH-1:0]                      ch_enable,
    input  logic                                   hold,
    input  logic                                   next,
    output logic [(NUM_CH>1?$clog2(NUM_CH):1)-1:0] ch_sel,
    output logic [NUM_DIG-1:0]                     an,
    output logic [6:0]                             seg,
    output logic [1:0]                             o_conv_state
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DWELL_W = $clog2(DWELL_CYC);
    localparam int SCAN_W  = $clog2(SCAN_CYC);
    localparam int DIG_W   = $clog2(NUM_DIG);
    localparam int BCD_W   = 4 * NUM_DIG;
    localparam int SH_W    = $clog2(VAL_W + 1);
`ifdef DISP_CH_TAG_EN
    localparam int VAL_DIG = NUM_DIG - 1;
`else
    localparam int VAL_DIG = NUM_DIG;
`endif
    localparam int DEC_MAX = 10 ** VAL_DIG - 1;
    localparam int SAT_EFF = (SAT_VAL < DEC_MAX) ? SAT_VAL : DEC_MAX;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [CH_W-1:0]    r_ch_sel;
    logic [DWELL_W-1:0] r_dwell;
    logic [SCAN_W-1:0]  r_scan;
    logic [DIG_W-1:0]   r_dig;
    logic [1:0]         r_state;
    logic [VAL_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_work;
    logic [SH_W-1:0]    r_shcnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_blank;
    logic [NUM_DIG-1:0] r_an;
    logic [6:0]         r_seg;

    logic [CH_W-1:0]    w_next_ch;
    logic               w_found;
    logic               w_any_en;
    logic               w_expire;
    logic               w_adv;
    logic               w_abort;
    logic [VAL_W-1:0]   w_sel_val;
    logic [VAL_W-1:0]   w_sat_val;
    logic [BCD_W-1:0]   w_adj;
    logic [DIG_W-1:0]   w_msnz;
    logic               w_dig_blank;
    logic [6:0]         w_glyph;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    // First enabled channel strictly above the current one, wrapping; the
    // current channel itself is reached last, so a lone channel stays put.
    always_comb begin
        w_next_ch = r_ch_sel;
        w_found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_found && ch_enable[(int'(r_ch_sel) + i) % NUM_CH]) begin
                w_next_ch = CH_W'((int'(r_ch_sel) + i) % NUM_CH);
                w_found   = 1'b1;
            end
        end
    end

    assign w_any_en  = |ch_enable;
    assign w_expire  = !hold && (r_dwell == DWELL_W'(DWELL_CYC - 1));
    assign w_adv     = w_any_en && (next || w_expire || !ch_enable[r_ch_sel]);
    assign w_abort   = (w_adv && (w_next_ch != r_ch_sel)) || !w_any_en;
    assign w_sel_val = ch_values[int'(r_ch_sel)*VAL_W +: VAL_W];
    assign w_sat_val = (32'(w_sel_val) > SAT_EFF) ? VAL_W'(SAT_EFF) : w_sel_val;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ch_sel <= '0;
            r_dwell  <= '0;
        end else begin
            if (w_adv) r_ch_sel <= w_next_ch;
            if (w_adv || next || w_expire) r_dwell <= '0;
            else if (!hold) r_dwell <= r_dwell + 1'b1;
        end
    end

    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
    end

    // The display register only moves in DONE, so a frame never mixes values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_LOAD;
            r_bin   <= '0;
            r_work  <= '0;
            r_shcnt <= '0;
            r_bcd   <= '0;
            r_blank <= 1'b1;
        end else if (w_abort) begin
            r_state <= ST_LOAD;
            r_blank <= 1'b1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_bin   <= w_sat_val;
                    r_work  <= '0;
                    r_shcnt <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_work  <= {w_adj[BCD_W-2:0], r_bin[VAL_W-1]};
                    r_bin   <= {r_bin[VAL_W-2:0], 1'b0};
                    r_shcnt <= r_shcnt + 1'b1;
                    if (r_shcnt == SH_W'(VAL_W - 1)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_bcd   <= r_work;
                    r_blank <= 1'b0;
                    r_state <= ST_LOAD;
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_scan <= '0;
            r_dig  <= '0;
        end else if (r_scan == SCAN_W'(SCAN_CYC - 1)) begin
            r_scan <= '0;
            r_dig  <= (r_dig == DIG_W'(NUM_DIG - 1)) ? '0 : r_dig + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_comb begin
        w_msnz = '0;
        for (int i = 0; i < VAL_DIG; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) w_msnz = DIG_W'(i);
        end
    end

    always_comb begin
        w_dig_blank = r_blank || (r_dig > w_msnz);
        w_glyph     = f_glyph(r_bcd[{r_dig, 2'b00} +: 4]);
`ifdef DISP_CH_TAG_EN
        if (r_dig == DIG_W'(NUM_DIG - 1)) begin
            w_dig_blank = r_blank;
            w_glyph     = f_glyph(4'(r_ch_sel));
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
        end else if (w_dig_blank) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(NUM_DIG'(1) << r_dig);
            r_seg <= w_glyph;
        end
    end

    assign ch_sel       = r_ch_sel;
    assign an           = r_an;
    assign seg          = r_seg;
    assign o_conv_state = r_state;
endmodule
